// File: rtl/local_memory_arbiter_pkg.sv
// Purpose: shared types, widths and helpers for the local memory arbiter.
//   state_e            : arbiter FSM states (IDLE arbitrates, ACTIVE forwards)
//   ADDRESS_WIDTH      : byte address width of the memory interface
//   DATA_WIDTH         : data bus width
//   BYTE_SELECT_WIDTH  : byte-lane select width
//   IDLE_READ_DATA     : read data shown to requesters that do not own the port
//   rr_next_index()    : next index in round-robin order, wrapping at count
package local_memory_arbiter_pkg;

  localparam int unsigned ADDRESS_WIDTH     = 24;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned BYTE_SELECT_WIDTH = 4;

  localparam logic [DATA_WIDTH-1:0] IDLE_READ_DATA = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Successor of index in a ring of count entries.
  function automatic int unsigned rr_next_index(input int unsigned index,
                                                input int unsigned count);
    if (index + 32'd1 >= count) begin
      return 32'd0;
    end
    return index + 32'd1;
  endfunction

endpackage

// File: rtl/local_memory_arbiter_round_robin_selector.sv
// Purpose: combinational round-robin pick over a request vector.
//   request_i    : one bit per requester, set when it wants the port
//   last_grant_i : most recently granted index; the search starts just after it
//   found_c_o    : at least one request is set
//   index_c_o    : first requesting index after last_grant_i, wrapping around
module round_robin_selector
  import local_memory_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTER_COUNT = 3,
  parameter int unsigned GRANT_WIDTH     = 2
) (
  input  logic [REQUESTER_COUNT-1:0] request_i,
  input  logic [GRANT_WIDTH-1:0]     last_grant_i,
  output logic                       found_c_o,
  output logic [GRANT_WIDTH-1:0]     index_c_o
);

  // Walk last+1, last+2, ... so last_grant_i itself is checked last.
  always_comb begin
    int unsigned candidate;
    found_c_o = 1'b0;
    index_c_o = '0;
    candidate = 32'(last_grant_i);
    for (int unsigned step = 0; step < REQUESTER_COUNT; step++) begin
      candidate = rr_next_index(candidate, REQUESTER_COUNT);
      if (!found_c_o && request_i[GRANT_WIDTH'(candidate)]) begin
        found_c_o = 1'b1;
        index_c_o = GRANT_WIDTH'(candidate);
      end
    end
  end

endmodule

// File: rtl/local_memory_arbiter.sv
// Purpose: round-robin arbiter sharing the memory interface wb port between
// several requesters (host, DMA, debug) using the enable/busy handshake.
//   clk, rst            : clock and synchronous active-high reset
//   requestAddress      : per-requester byte address, requester i at [i*AW +: AW]
//   requestByteSelect   : per-requester byte select
//   requestEnable       : per-requester request, held until its busy drops
//   requestWriteEnable  : per-requester write (1) / read (0)
//   requestDataWrite    : per-requester write data
//   requestDataRead     : per-requester read data (all ones unless granted)
//   requestBusy         : per-requester busy
//   mem*                : towards the memory interface wb port
// mem* and request* outputs are combinational muxes of the granted requester.
module local_memory_arbiter
  import local_memory_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTER_COUNT = 3,
  parameter int unsigned ADDRESS_WIDTH   = 24
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [REQUESTER_COUNT*ADDRESS_WIDTH-1:0]     requestAddress,
  input  logic [REQUESTER_COUNT*BYTE_SELECT_WIDTH-1:0] requestByteSelect,
  input  logic [REQUESTER_COUNT-1:0]                  requestEnable,
  input  logic [REQUESTER_COUNT-1:0]                  requestWriteEnable,
  input  logic [REQUESTER_COUNT*DATA_WIDTH-1:0]        requestDataWrite,
  output logic [REQUESTER_COUNT*DATA_WIDTH-1:0]        requestDataRead,
  output logic [REQUESTER_COUNT-1:0]                  requestBusy,
  output logic [ADDRESS_WIDTH-1:0]                    memAddress,
  output logic [BYTE_SELECT_WIDTH-1:0]                memByteSelect,
  output logic                                        memEnable,
  output logic                                        memWriteEnable,
  output logic [DATA_WIDTH-1:0]                       memDataWrite,
  input  logic [DATA_WIDTH-1:0]                       memDataRead,
  input  logic                                        memBusy
);

  localparam int unsigned GRANT_WIDTH =
    (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;
  localparam logic [GRANT_WIDTH-1:0] LAST_GRANT_RESET =
    GRANT_WIDTH'(REQUESTER_COUNT - 1);

  state_e                  state_q, state_d;
  logic [GRANT_WIDTH-1:0]  grant_index_q, grant_index_d;
  logic [GRANT_WIDTH-1:0]  last_grant_q, last_grant_d;

  logic                    sel_found_c;
  logic [GRANT_WIDTH-1:0]  sel_index_c;
  logic                    grant_enable_c;

  // Next requester in round-robin order after the last grant.
  round_robin_selector #(
    .REQUESTER_COUNT (REQUESTER_COUNT),
    .GRANT_WIDTH     (GRANT_WIDTH)
  ) u_selector (
    .request_i    (requestEnable),
    .last_grant_i (last_grant_q),
    .found_c_o    (sel_found_c),
    .index_c_o    (sel_index_c)
  );

  // State register; reset leaves the pointer so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_index_q <= '0;
      last_grant_q  <= LAST_GRANT_RESET;
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      last_grant_q  <= last_grant_d;
    end
  end

  // Next-state logic and port muxing.
  always_comb begin
    state_d         = state_q;
    grant_index_d   = grant_index_q;
    last_grant_d    = last_grant_q;
    grant_enable_c  = 1'b0;
    memAddress      = '0;
    memByteSelect   = '0;
    memEnable       = 1'b0;
    memWriteEnable  = 1'b0;
    memDataWrite    = '0;
    requestBusy     = requestEnable;
    requestDataRead = {REQUESTER_COUNT{IDLE_READ_DATA}};

    case (state_q)
      IDLE: begin
        if (sel_found_c) begin
          grant_index_d = sel_index_c;
          last_grant_d  = sel_index_c;
          state_d       = ACTIVE;
        end
      end

      ACTIVE: begin
        for (int unsigned i = 0; i < REQUESTER_COUNT; i++) begin
          if (grant_index_q == GRANT_WIDTH'(i)) begin
            grant_enable_c = requestEnable[i];
            memAddress     = requestAddress[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            memByteSelect  = requestByteSelect[i*BYTE_SELECT_WIDTH +: BYTE_SELECT_WIDTH];
            memWriteEnable = requestWriteEnable[i];
            memDataWrite   = requestDataWrite[i*DATA_WIDTH +: DATA_WIDTH];
            requestBusy[i] = memBusy;
            requestDataRead[i*DATA_WIDTH +: DATA_WIDTH] = memDataRead;
          end
        end
        memEnable = grant_enable_c;
        // Completion (busy low) and abort (enable dropped) both release the port.
        if (!grant_enable_c || !memBusy) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset forces the port quiet in the same cycle, even mid-transaction.
    if (rst) begin
      memAddress      = '0;
      memByteSelect   = '0;
      memEnable       = 1'b0;
      memWriteEnable  = 1'b0;
      memDataWrite    = '0;
      requestBusy     = requestEnable;
      requestDataRead = {REQUESTER_COUNT{IDLE_READ_DATA}};
    end
  end

endmodule
